// File: rtl/encoder_code_fifo.sv
// Captures each new valid {V,Y} code from the 4-to-2 encoder into a FWFT FIFO drained over valid/ready.
// Optional overflow drop counter enabled by defining ENCODER_CODE_FIFO_DROP_CNT_EN.
module encoder_code_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       V,
    input  logic [1:0]                 Y,
    output logic                       out_valid,
    output logic [1:0]                 out_code,
    input  logic                       out_ready,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic             v_q;
    logic [1:0]       y_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [1:0]       mem_q [DEPTH];

    logic evt;
    logic push;
    logic pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign count     = count_q;
    assign out_valid = ~empty;
    assign out_code  = empty ? 2'b00 : mem_q[rd_ptr_q];

    // New code: V rising, or Y moving while V stays high.
    assign evt  = V & (~v_q | (Y != y_q));
    assign pop  = out_valid & out_ready;
    assign push = evt & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= 1'b0;
            y_q      <= 2'b00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            v_q      <= V;
            y_q      <= Y;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uninitialised; out_code masks it while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= Y;
    end

`ifdef ENCODER_CODE_FIFO_DROP_CNT_EN
    localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);

    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (evt && full && !pop && (drop_cnt_q != DROP_MAX))
            drop_cnt_d = drop_cnt_q + DROP_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_encoder_code_fifo.sv
// Directed self-checking bench for encoder_code_fifo (DEPTH=4, CNT_W=8).
module tb_encoder_code_fifo;

    logic       clk;
    logic       rst_n;
    logic       V;
    logic [1:0] Y;
    logic       out_valid;
    logic [1:0] out_code;
    logic       out_ready;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic [7:0] drop_cnt;

    int checks;
    int errors;

    encoder_code_fifo #(.DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .V         (V),
        .Y         (Y),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then settle 1 time unit past it.
    task automatic step(input logic v, input logic [1:0] y, input logic rdy);
        V = v;
        Y = y;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        V = 1'b0;
        Y = 2'b00;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || count !== 3'd0 ||
            out_code !== 2'b00 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b empty=%b full=%b count=%0d code=%b drop=%0d, required 0 1 0 0 00 0",
                     out_valid, empty, full, count, out_code, drop_cnt);
        end
    endtask

    task automatic test_held_code();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 2'b10, 1'b0);
        checks++;
        if (count !== 3'd1 || out_code !== 2'b10 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL held_code: count=%0d code=%b valid=%b, required 1 10 1", count, out_code, out_valid);
        end
    endtask

    task automatic test_sequence_drain();
        logic [1:0] exp_codes [4];
        exp_codes = '{2'b00, 2'b01, 2'b01, 2'b11};
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b11, 1'b0);
        checks++;
        if (count !== 3'd4 || full !== 1'b1) begin
            errors++;
            $display("FAIL seq_fill: count=%0d full=%b, required 4 1", count, full);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_code !== exp_codes[i]) begin
                errors++;
                $display("FAIL seq_drain[%0d]: valid=%b code=%b, required 1 %b", i, out_valid, out_code, exp_codes[i]);
            end
            step(1'b0, 2'b00, 1'b1);
        end
        checks++;
        if (empty !== 1'b1 || out_valid !== 1'b0 || out_code !== 2'b00) begin
            errors++;
            $display("FAIL seq_empty: empty=%b valid=%b code=%b, required 1 0 00", empty, out_valid, out_code);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] exp_codes [4];
        logic [7:0] exp_drop;
        exp_codes = '{2'b00, 2'b01, 2'b10, 2'b11};
`ifdef ENCODER_CODE_FIFO_DROP_CNT_EN
        exp_drop = 8'd3;
`else
        exp_drop = 8'd0;
`endif
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b11, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || out_code !== 2'b00) begin
            errors++;
            $display("FAIL overflow_state: count=%0d full=%b head=%b, required 4 1 00", count, full, out_code);
        end
        checks++;
        if (drop_cnt !== exp_drop) begin
            errors++;
            $display("FAIL overflow_drop_cnt: got %0d, required %0d", drop_cnt, exp_drop);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_code !== exp_codes[i]) begin
                errors++;
                $display("FAIL overflow_contents[%0d]: valid=%b code=%b, required 1 %b", i, out_valid, out_code, exp_codes[i]);
            end
            step(1'b0, 2'b00, 1'b1);
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL overflow_empty: empty=%b, required 1", empty);
        end
    endtask

    task automatic test_full_push_pop();
        logic [1:0] exp_codes [4];
        exp_codes = '{2'b01, 2'b10, 2'b11, 2'b10};
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b11, 1'b0);
        step(1'b1, 2'b10, 1'b1);
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d full=%b drop=%0d, required 4 1 0", count, full, drop_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_code !== exp_codes[i]) begin
                errors++;
                $display("FAIL full_push_pop_drain[%0d]: valid=%b code=%b, required 1 %b", i, out_valid, out_code, exp_codes[i]);
            end
            step(1'b0, 2'b00, 1'b1);
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop_empty: empty=%b, required 1", empty);
        end
    endtask

    task automatic test_empty_passthrough();
        do_reset();
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL passthru_pre: valid=%b, required 0", out_valid);
        end
        step(1'b1, 2'b11, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_code !== 2'b11 || count !== 3'd1) begin
            errors++;
            $display("FAIL passthru_appear: valid=%b code=%b count=%0d, required 1 11 1", out_valid, out_code, count);
        end
        step(1'b1, 2'b11, 1'b1);
        checks++;
        if (empty !== 1'b1 || out_valid !== 1'b0 || out_code !== 2'b00) begin
            errors++;
            $display("FAIL passthru_consumed: empty=%b valid=%b code=%b, required 1 0 00", empty, out_valid, out_code);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_drop;
`ifdef ENCODER_CODE_FIFO_DROP_CNT_EN
        exp_drop = 8'd1;
`else
        exp_drop = 8'd0;
`endif
        do_reset();
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b11, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        checks++;
        if (count !== 3'd3 || out_code !== 2'b01 || drop_cnt !== exp_drop) begin
            errors++;
            $display("FAIL pre_reset: count=%0d code=%b drop=%0d, required 3 01 %0d", count, out_code, drop_cnt, exp_drop);
        end
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        V = 1'b1;
        Y = 2'b01;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || drop_cnt !== 8'd0 || empty !== 1'b1 ||
            full !== 1'b0 || out_code !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: valid=%b count=%0d drop=%0d empty=%b full=%b code=%b, required 0 0 0 1 0 00",
                     out_valid, count, drop_cnt, empty, full, out_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b0);
        checks++;
        if (count !== 3'd1 || out_code !== 2'b01 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_entry: count=%0d code=%b valid=%b, required 1 01 1", count, out_code, out_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        V = 1'b0;
        Y = 2'b00;
        out_ready = 1'b0;
        test_reset();
        test_held_code();
        test_sequence_drain();
        test_overflow();
        test_full_push_pop();
        test_empty_passthrough();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
